lcd_read_fsm: RTL

- Read-side companion to the LCD write sequencer. Performs HD44780-style read cycles (RW=1): either a data-register read or a busy-flag/address-counter read.
- Optional polling mode re-reads the busy flag until it clears or a poll limit is reached.
- Sits beside the write sequencer on the shared LCD bus. An external arbiter grants the bus using the `busy` output.

---
 rtl/lcd_read_fsm_if.sv | 27 ++
 rtl/lcd_read_fsm.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_read_fsm_if.sv
// Bus bundle between the LCD read sequencer and its controller / pad logic.
// The master side issues read requests; the slave side is the sequencer.
interface lcd_read_fsm_if;
  logic       en;
  logic       readReq;
  logic       RSin;
  logic       pollBusy;
  logic [7:0] lcdDataIn;
  logic       RSout;
  logic       RWout;
  logic       enable;
  logic       busRelease;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       timeout;
  logic       busy;

  modport master (
    output en, readReq, RSin, pollBusy, lcdDataIn,
    input  RSout, RWout, enable, busRelease, dataOut, dataValid, timeout, busy
  );

  modport slave (
    input  en, readReq, RSin, pollBusy, lcdDataIn,
    output RSout, RWout, enable, busRelease, dataOut, dataValid, timeout, busy
  );
endinterface

// File: rtl/lcd_read_fsm.sv
// HD44780-style read sequencer: data-register or busy-flag reads, with an
// optional poll mode that re-reads the busy flag until it clears or a limit hits.
module lcd_read_fsm #(
  parameter int SETUP_CYC  = 1,
  parameter int E_HIGH_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int POLL_MAX   = 255
) (
  input  logic          int_osc,
  input  logic          reset,
  lcd_read_fsm_if.slave bus
);

  localparam int MAX_AB = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int PW  = $clog2(MAX_CYC + 1);
  localparam int PCW = $clog2(POLL_MAX + 1);

  localparam logic [PW-1:0]  SETUP_LAST = PW'(SETUP_CYC - 1);
  localparam logic [PW-1:0]  EHIGH_LAST = PW'(E_HIGH_CYC - 1);
  localparam logic [PW-1:0]  HOLD_LAST  = PW'(HOLD_CYC - 1);
  localparam logic [PCW-1:0] POLL_LAST  = PCW'(POLL_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EHIGH = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic           rs_lat_q, rs_lat_d;
  logic           poll_lat_q, poll_lat_d;
  logic           timeout_lat_q, timeout_lat_d;
  logic [7:0]     data_q, data_d;

  logic rs_out_q, rs_out_d;
  logic rw_out_q, rw_out_d;
  logic e_out_q, e_out_d;
  logic release_q, release_d;
  logic valid_q, valid_d;
  logic timeout_q, timeout_d;
  logic busy_q, busy_d;

  // Next-state, latches and output decode; outputs are decoded from the next
  // state so that the registered pins always match the registered state.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    poll_cnt_d    = poll_cnt_q;
    rs_lat_d      = rs_lat_q;
    poll_lat_d    = poll_lat_q;
    timeout_lat_d = timeout_lat_q;
    data_d        = data_q;

    if (bus.en) begin
      case (state_q)
        S_IDLE: begin
          if (bus.readReq) begin
            rs_lat_d   = bus.pollBusy ? 1'b0 : bus.RSin;
            poll_lat_d = bus.pollBusy;
            poll_cnt_d = '0;
            phase_d    = '0;
            state_d    = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SETUP: begin
          if (phase_q == SETUP_LAST) begin
            phase_d = '0;
            state_d = S_EHIGH;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_EHIGH: begin
          // Capture on the edge that ends the pulse, while E is still high.
          if (phase_q == EHIGH_LAST) begin
            data_d  = bus.lcdDataIn;
            phase_d = '0;
            state_d = S_HOLD;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_HOLD: begin
          if (phase_q == HOLD_LAST) begin
            phase_d = '0;
            if (poll_lat_q && data_q[7]) begin
              if (poll_cnt_q == POLL_LAST) begin
                timeout_lat_d = 1'b1;
                state_d       = S_DONE;
              end else begin
                poll_cnt_d = poll_cnt_q + PCW'(1);
                state_d    = S_SETUP;
              end
            end else begin
              state_d = S_DONE;
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_DONE: begin
          timeout_lat_d = 1'b0;
          state_d       = S_IDLE;
        end
        default: begin
          phase_d       = '0;
          poll_cnt_d    = '0;
          timeout_lat_d = 1'b0;
          state_d       = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    rs_out_d  = 1'b0;
    rw_out_d  = 1'b0;
    e_out_d   = 1'b0;
    release_d = 1'b0;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    busy_d    = 1'b0;
    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_SETUP, S_HOLD: begin
        rs_out_d  = rs_lat_d;
        rw_out_d  = 1'b1;
        release_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_EHIGH: begin
        rs_out_d  = rs_lat_d;
        rw_out_d  = 1'b1;
        e_out_d   = 1'b1;
        release_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_DONE: begin
        rs_out_d  = rs_lat_d;
        rw_out_d  = 1'b1;
        release_d = 1'b1;
        valid_d   = 1'b1;
        timeout_d = timeout_lat_d;
        busy_d    = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, latch and output registers with synchronous active-low reset.
  always_ff @(posedge int_osc) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      poll_cnt_q    <= '0;
      rs_lat_q      <= 1'b0;
      poll_lat_q    <= 1'b0;
      timeout_lat_q <= 1'b0;
      data_q        <= 8'h00;
      rs_out_q      <= 1'b0;
      rw_out_q      <= 1'b0;
      e_out_q       <= 1'b0;
      release_q     <= 1'b0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      poll_cnt_q    <= poll_cnt_d;
      rs_lat_q      <= rs_lat_d;
      poll_lat_q    <= poll_lat_d;
      timeout_lat_q <= timeout_lat_d;
      data_q        <= data_d;
      rs_out_q      <= rs_out_d;
      rw_out_q      <= rw_out_d;
      e_out_q       <= e_out_d;
      release_q     <= release_d;
      valid_q       <= valid_d;
      timeout_q     <= timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.RSout      = rs_out_q;
  assign bus.RWout      = rw_out_q;
  assign bus.enable     = e_out_q;
  assign bus.busRelease = release_q;
  assign bus.dataOut    = data_q;
  assign bus.dataValid  = valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = busy_q;

endmodule
